// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit knight ALU tile.
//   WIDTH       : operand/result width (fixed, the pin map depends on it)
//   OP_*        : 16 opcode encodings carried on uio_in[3:0]
//   *_BIT       : positions of the NZCV flags within uo_out
package alu4_pkg;

    localparam int WIDTH = 4;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADC  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SBC  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NAND = 4'd7;
    localparam logic [3:0] OP_NOT  = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_ASR  = 4'd11;
    localparam logic [3:0] OP_ROL  = 4'd12;
    localparam logic [3:0] OP_ROR  = 4'd13;
    localparam logic [3:0] OP_INC  = 4'd14;
    localparam logic [3:0] OP_DEC  = 4'd15;

    localparam int C_BIT = 4;
    localparam int Z_BIT = 5;
    localparam int N_BIT = 6;
    localparam int V_BIT = 7;

endpackage

// File: rtl/alu4_core.sv
// Combinational 4-bit ALU datapath.
//   a, b : operands
//   op   : opcode (see alu4_pkg)
//   cin  : carry-in, only consumed by ADC and SBC
//   r    : result
//   c, z, n, v : carry, zero, negative, signed-overflow flags
module alu4_core
    import alu4_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             cin,
    output logic [WIDTH-1:0] r,
    output logic             c,
    output logic             z,
    output logic             n,
    output logic             v
);

    // Every arithmetic opcode is a single adder pass: a + y + ci.
    logic [WIDTH-1:0] y;
    logic             ci;
    logic             arith;
    logic [WIDTH:0]   sum;

    always_comb begin
        y     = '0;
        ci    = 1'b0;
        arith = 1'b0;
        case (op)
            OP_ADD: begin y = b;       arith = 1'b1; end
            OP_ADC: begin y = b;       ci = cin;  arith = 1'b1; end
            OP_SUB: begin y = ~b;      ci = 1'b1; arith = 1'b1; end
            OP_SBC: begin y = ~b;      ci = cin;  arith = 1'b1; end
            OP_INC: begin y = 4'b0001; arith = 1'b1; end
            OP_DEC: begin y = 4'b1111; arith = 1'b1; end
            default: ;
        endcase
    end

    assign sum = {1'b0, a} + {1'b0, y} + {{WIDTH{1'b0}}, ci};

    always_comb begin
        r = '0;
        c = 1'b0;
        v = 1'b0;
        if (arith) begin
            r = sum[WIDTH-1:0];
            c = sum[WIDTH];
            // Overflow: both adder inputs share a sign that the result lost.
            v = (a[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end else begin
            case (op)
                OP_AND:  r = a & b;
                OP_OR:   r = a | b;
                OP_XOR:  r = a ^ b;
                OP_NAND: r = ~(a & b);
                OP_NOT:  r = ~a;
                OP_SHL:  begin r = {a[2:0], 1'b0};  c = a[3]; end
                OP_SHR:  begin r = {1'b0, a[3:1]};  c = a[0]; end
                OP_ASR:  begin r = {a[3], a[3:1]};  c = a[0]; end
                OP_ROL:  begin r = {a[2:0], a[3]};  c = a[3]; end
                OP_ROR:  begin r = {a[0], a[3:1]};  c = a[0]; end
                default: ;
            endcase
        end
    end

    assign z = (r == '0);
    assign n = r[WIDTH-1];

endmodule

// File: rtl/tt_um_ariggan_knight_alu4.sv
// Tiny Tapeout tile: registered 4-bit ALU with NZCV flags.
//   clk     : clock, rising edge
//   rst_n   : synchronous reset, active HIGH despite the harness name
//   ena     : clock enable; registers hold when low
//   ui_in   : [3:0]=A, [7:4]=B
//   uio_in  : [3:0]=OP, [4]=CIN, [7:5] unused
//   uo_out  : [3:0]=R, [4]=C, [5]=Z, [6]=N, [7]=V (registered)
//   uio_out : tied to 0
//   uio_oe  : tied to 0, all bidirectional pins are inputs
module tt_um_ariggan_knight_alu4
    import alu4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [WIDTH-1:0] r;
    logic             c;
    logic             z;
    logic             n;
    logic             v;
    logic [7:0]       res_p0;
    logic [7:0]       out_p1;
    logic             unused_uio;

    alu4_core u_core (
        .a   (ui_in[3:0]),
        .b   (ui_in[7:4]),
        .op  (uio_in[3:0]),
        .cin (uio_in[4]),
        .r   (r),
        .c   (c),
        .z   (z),
        .n   (n),
        .v   (v)
    );

    always_comb begin
        res_p0          = '0;
        res_p0[3:0]     = r;
        res_p0[C_BIT]   = c;
        res_p0[Z_BIT]   = z;
        res_p0[N_BIT]   = n;
        res_p0[V_BIT]   = v;
    end

    // Stage p0 -> p1: output register; reset wins over enable.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            out_p1 <= '0;
        end else if (ena) begin
            out_p1 <= res_p0;
        end
    end

    assign uo_out     = out_p1;
    assign uio_out    = '0;
    assign uio_oe     = '0;
    assign unused_uio = &uio_in[7:5];

endmodule

// File: tb/tb_tt_um_ariggan_knight_alu4.sv
module tb_tt_um_ariggan_knight_alu4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_vec;
    int n_bad;

    tt_um_ariggan_knight_alu4 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic       cin;
        logic [2:0] junk;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                         input logic cin, input logic [2:0] junk);
        ui_in  = {b, a};
        uio_in = {junk, cin, op};
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        //                name          a      b      op     cin  junk  exp
        vecs[0]  = '{"add_ovf",   4'h7, 4'h1, 4'd0,  1'b0, 3'd0, 8'hC8};
        vecs[1]  = '{"sub_eq",    4'h5, 4'h5, 4'd2,  1'b0, 3'd0, 8'h30};
        vecs[2]  = '{"adc_wrap",  4'hF, 4'h0, 4'd1,  1'b1, 3'd0, 8'h30};
        vecs[3]  = '{"shl",       4'h9, 4'h0, 4'd9,  1'b0, 3'd0, 8'h12};
        vecs[4]  = '{"asr",       4'h8, 4'h0, 4'd11, 1'b0, 3'd0, 8'h4C};
        vecs[5]  = '{"dec_zero",  4'h0, 4'h0, 4'd15, 1'b0, 3'd0, 8'h4F};
        vecs[6]  = '{"inc_ovf",   4'h7, 4'h0, 4'd14, 1'b0, 3'd0, 8'hC8};
        vecs[7]  = '{"inc_wrap",  4'hF, 4'h0, 4'd14, 1'b0, 3'd0, 8'h30};
        vecs[8]  = '{"dec_ovf",   4'h8, 4'h0, 4'd15, 1'b0, 3'd0, 8'h97};
        vecs[9]  = '{"sbc_c1",    4'h5, 4'h3, 4'd3,  1'b1, 3'd0, 8'h12};
        vecs[10] = '{"sbc_c0",    4'h5, 4'h3, 4'd3,  1'b0, 3'd0, 8'h11};
        vecs[11] = '{"add_cin",   4'h3, 4'h4, 4'd0,  1'b1, 3'd0, 8'h07};
        vecs[12] = '{"or",        4'hA, 4'h5, 4'd5,  1'b0, 3'd0, 8'h4F};
        vecs[13] = '{"xor_self",  4'h6, 4'h6, 4'd6,  1'b0, 3'd0, 8'h20};
        vecs[14] = '{"nand",      4'hC, 4'hA, 4'd7,  1'b1, 3'd0, 8'h07};
        vecs[15] = '{"not",       4'h5, 4'h0, 4'd8,  1'b0, 3'd0, 8'h4A};
        vecs[16] = '{"shr",       4'h9, 4'h0, 4'd10, 1'b0, 3'd0, 8'h14};
        vecs[17] = '{"rol",       4'h9, 4'h0, 4'd12, 1'b0, 3'd0, 8'h13};
        vecs[18] = '{"ror",       4'h9, 4'h0, 4'd13, 1'b0, 3'd0, 8'h5C};
        vecs[19] = '{"sub_neg",   4'h3, 4'h5, 4'd2,  1'b0, 3'd0, 8'h4E};
        vecs[20] = '{"sub_ovf",   4'h8, 4'h1, 4'd2,  1'b1, 3'd7, 8'h97};
        vecs[21] = '{"add_ovf2",  4'h8, 4'h8, 4'd0,  1'b0, 3'd5, 8'hB0};

        // Reset with non-zero operands on the inputs.
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'hFF;
        uio_in = 8'h00;
        tick();
        tick();
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        rst_n = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin, vecs[i].junk);
            tick();
            check(vecs[i].name, uo_out, vecs[i].exp);
        end

        // Hold while disabled, then resume.
        drive(4'h7, 4'h1, 4'd0, 1'b0, 3'd0);
        tick();
        check("hold_pre", uo_out, 8'hC8);
        ena = 1'b0;
        drive(4'h0, 4'h0, 4'd4, 1'b0, 3'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold", uo_out, 8'hC8);
        end
        ena = 1'b1;
        tick();
        check("hold_resume", uo_out, 8'h20);

        // Reset takes priority over a live enable, then operation resumes.
        drive(4'h7, 4'h1, 4'd0, 1'b0, 3'd0);
        tick();
        check("prio_pre", uo_out, 8'hC8);
        drive(4'h5, 4'h5, 4'd2, 1'b0, 3'd0);
        rst_n = 1'b1;
        tick();
        check("prio_reset", uo_out, 8'h00);
        rst_n = 1'b0;
        tick();
        check("prio_resume", uo_out, 8'h30);

        // Reset also clears while disabled.
        ena   = 1'b0;
        rst_n = 1'b1;
        tick();
        check("reset_no_ena", uo_out, 8'h00);
        rst_n = 1'b0;
        tick();
        check("reset_no_ena_hold", uo_out, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
